// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and the D->E
// pipeline record with its bubble value.
package y86_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [XLEN-1:0] valc;
    logic [XLEN-1:0] vala;
    logic [XLEN-1:0] valb;
    logic [3:0]      srca;
    logic [3:0]      srcb;
    logic [3:0]      dste;
    logic [3:0]      dstm;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    icode: INOP,
    ifun:  4'h0,
    valc:  {XLEN{1'b0}},
    vala:  {XLEN{1'b0}},
    valb:  {XLEN{1'b0}},
    srca:  RNONE,
    srcb:  RNONE,
    dste:  RNONE,
    dstm:  RNONE
  };

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two write ports (M port wins on a shared ID) and two
// combinational read ports that bypass the values being written this cycle.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int W = 64,
  parameter int N = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   wr_e_id_i,
  input  logic [W-1:0] wr_e_data_i,
  input  logic [3:0]   wr_m_id_i,
  input  logic [W-1:0] wr_m_data_i,
  input  logic [3:0]   rd_a_id_i,
  output logic [W-1:0] rd_a_data_o,
  input  logic [3:0]   rd_b_id_i,
  output logic [W-1:0] rd_b_data_o
);

  logic [W-1:0] regs_q [N];
  logic [W-1:0] regs_d [N];

  // Next array state; the M write is applied last so it overrides E
  always_comb begin
    regs_d = regs_q;
    if (wr_e_id_i != RNONE) begin
      regs_d[wr_e_id_i] = wr_e_data_i;
    end else begin
      regs_d = regs_d;
    end
    if (wr_m_id_i != RNONE) begin
      regs_d[wr_m_id_i] = wr_m_data_i;
    end else begin
      regs_d = regs_d;
    end
  end

  // Array update with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= {W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: RNONE reads zero, otherwise the W-stage bypass takes precedence
  always_comb begin
    rd_a_data_o = {W{1'b0}};
    rd_b_data_o = {W{1'b0}};
    if (rd_a_id_i == RNONE) begin
      rd_a_data_o = {W{1'b0}};
    end else if (rd_a_id_i == wr_m_id_i) begin
      rd_a_data_o = wr_m_data_i;
    end else if (rd_a_id_i == wr_e_id_i) begin
      rd_a_data_o = wr_e_data_i;
    end else begin
      rd_a_data_o = regs_q[rd_a_id_i];
    end
    if (rd_b_id_i == RNONE) begin
      rd_b_data_o = {W{1'b0}};
    end else if (rd_b_id_i == wr_m_id_i) begin
      rd_b_data_o = wr_m_data_i;
    end else if (rd_b_id_i == wr_e_id_i) begin
      rd_b_data_o = wr_e_data_i;
    end else begin
      rd_b_data_o = regs_q[rd_b_id_i];
    end
  end

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register ID decode, operand read with write-back
// bypass, valA merge and the stallable D->E pipeline register.
module decode_regfile
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      D_icode,
  input  logic [3:0]      D_ifun,
  input  logic [3:0]      D_rA,
  input  logic [3:0]      D_rB,
  input  logic [XLEN-1:0] D_valC,
  input  logic [XLEN-1:0] D_valP,
  input  logic            D_stall,
  input  logic            D_bubble,
  input  logic [3:0]      W_dstE,
  input  logic [3:0]      W_dstM,
  input  logic [XLEN-1:0] W_valE,
  input  logic [XLEN-1:0] W_valM,
  output logic [3:0]      E_icode,
  output logic [3:0]      E_ifun,
  output logic [XLEN-1:0] E_valC,
  output logic [XLEN-1:0] E_valA,
  output logic [XLEN-1:0] E_valB,
  output logic [3:0]      E_srcA,
  output logic [3:0]      E_srcB,
  output logic [3:0]      E_dstE,
  output logic [3:0]      E_dstM,
  output logic [3:0]      d_srcA,
  output logic [3:0]      d_srcB
);

  logic [3:0]      src_a_s;
  logic [3:0]      src_b_s;
  logic [3:0]      dst_e_s;
  logic [3:0]      dst_m_s;
  logic [XLEN-1:0] rd_a_s;
  logic [XLEN-1:0] rd_b_s;
  logic [XLEN-1:0] val_a_s;
  e_reg_t          e_d;
  e_reg_t          e_q;

  // Register ID decode; unlisted and illegal icodes use no registers
  always_comb begin
    src_a_s = RNONE;
    src_b_s = RNONE;
    dst_e_s = RNONE;
    dst_m_s = RNONE;
    case (D_icode)
      IRRMOVQ: begin src_a_s = D_rA; dst_e_s = D_rB; end
      IIRMOVQ: begin dst_e_s = D_rB; end
      IRMMOVQ: begin src_a_s = D_rA; src_b_s = D_rB; end
      IMRMOVQ: begin src_b_s = D_rB; dst_m_s = D_rA; end
      IOPQ:    begin src_a_s = D_rA; src_b_s = D_rB; dst_e_s = D_rB; end
      ICALL:   begin src_b_s = RRSP; dst_e_s = RRSP; end
      IRET:    begin src_a_s = RRSP; src_b_s = RRSP; dst_e_s = RRSP; end
      IPUSHQ:  begin src_a_s = D_rA; src_b_s = RRSP; dst_e_s = RRSP; end
      IPOPQ:   begin src_a_s = RRSP; src_b_s = RRSP; dst_e_s = RRSP; dst_m_s = D_rA; end
      default: begin
        src_a_s = RNONE;
        src_b_s = RNONE;
        dst_e_s = RNONE;
        dst_m_s = RNONE;
      end
    endcase
  end

  y86_regfile #(
    .W (XLEN),
    .N (NREG)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .wr_e_id_i   (W_dstE),
    .wr_e_data_i (W_valE),
    .wr_m_id_i   (W_dstM),
    .wr_m_data_i (W_valM),
    .rd_a_id_i   (src_a_s),
    .rd_a_data_o (rd_a_s),
    .rd_b_id_i   (src_b_s),
    .rd_b_data_o (rd_b_s)
  );

  // jXX and call carry the fall-through PC in valA instead of a register
  always_comb begin
    if ((D_icode == IJXX) || (D_icode == ICALL)) begin
      val_a_s = D_valP;
    end else begin
      val_a_s = rd_a_s;
    end
  end

  // Assemble the next E record
  always_comb begin
    e_d       = E_BUBBLE;
    e_d.icode = D_icode;
    e_d.ifun  = D_ifun;
    e_d.valc  = D_valC;
    e_d.vala  = val_a_s;
    e_d.valb  = rd_b_s;
    e_d.srca  = src_a_s;
    e_d.srcb  = src_b_s;
    e_d.dste  = dst_e_s;
    e_d.dstm  = dst_m_s;
  end

  // E pipeline register: reset, then stall, then bubble, then load
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= E_BUBBLE;
    end else if (D_stall) begin
      e_q <= e_q;
    end else if (D_bubble) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valc;
  assign E_valA  = e_q.vala;
  assign E_valB  = e_q.valb;
  assign E_srcA  = e_q.srca;
  assign E_srcB  = e_q.srcb;
  assign E_dstE  = e_q.dste;
  assign E_dstM  = e_q.dstm;
  assign d_srcA  = src_a_s;
  assign d_srcB  = src_b_s;

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Decode stage for the pipelined Y86-64 core, holding the 15-entry register file. It derives source and destination register IDs from the D-stage instruction and reads operands, bypassing same-cycle writes from the write-back stage. Results are registered into the D→E pipeline register, which supports stall and bubble controls. It is the read-side counterpart of write-back: write-back drives the two write ports, and this block consumes them.

## Interface
- `XLEN`, 64: register and data width.
- `NREG`, 15: architectural registers; IDs 0..14 (rax..r14). 0xF = RNONE.
- `clk  in  1`: sole clock; all state updates on posedge.
- `rst  in  1`: synchronous, active-high reset.
- `D_icode, D_ifun  in  4 each`: D-stage instruction code and function.
- `D_rA, D_rB  in  4 each`: register specifiers from fetch.
- `D_valC, D_valP  in  XLEN each`: constant word and next PC.
- `D_stall  in  1`: hold E register.
- `D_bubble  in  1`: load nop into E register.
- `W_dstE, W_dstM  in  4 each`: write-back destinations; RNONE = no write.
- `W_valE, W_valM  in  XLEN each`: write-back data.
- `E_icode, E_ifun  out  4 each`: registered instruction fields.
- `E_valC, E_valA, E_valB  out  XLEN each`: registered constant and operands.
- `E_srcA, E_srcB, E_dstE, E_dstM  out  4 each`: registered register IDs.
- `d_srcA, d_srcB  out  4 each`: combinational source IDs, for hazard detection.

## Operation
- srcA:
  - rA for icode 2 (rrmovq/cmov), 4, 6, A.
  - 4 (rsp) for 9, B.
  - Otherwise F.
- srcB:
  - rB for 4, 5, 6.
  - 4 for 8, 9, A, B.
  - Otherwise F.
- dstE:
  - rB for 2, 3, 6.
  - 4 for 8, 9, A, B.
  - Otherwise F.
  - cmov condition is applied downstream, not here.
- dstM: rA for 5 and B; otherwise F.
- Operand read (combinational), for src = srcA or srcB:
  - src==F → 0.
  - Else if src==W_dstM → W_valM.
  - Else if src==W_dstE → W_valE.
  - Else R[src].
- valA merge: icode 7 (jXX) or 8 (call) → E_valA source is D_valP instead of the register read.
- Register write at posedge:
  - W_dstE≠F → R[W_dstE] ← W_valE.
  - W_dstM≠F → R[W_dstM] ← W_valM.
  - Same ID on both ports → valM wins. This gives correct popq %rsp.
- E register update priority:
  1. rst.
  2. D_stall: hold all E outputs.
  3. D_bubble: load bubble.
  4. Otherwise load decoded values.
- Bubble and reset value:
  - E_icode=1 (nop), E_ifun=0.
  - All E_src/E_dst = F.
  - All E_val = 0.
- Reset:
  - All R[i] ← 0 and the E register ← bubble on the first posedge with rst=1.
  - Writes presented during reset cycles are discarded.
  - Reset mid-stream wins over stall, bubble and writes.
- Illegal icode (C..F): all IDs F, operands 0, fields passed through.

## Timing
- Decode is combinational from D inputs. E outputs are valid one cycle after the D inputs are presented.
- Write at edge N:
  - Visible through the bypass during the cycle ending at edge N.
  - Visible from the array after edge N.
  - An instruction in D sees the value in the same cycle the writer is in W.
- Stall held for k cycles → E outputs constant for k cycles; register writes continue during the stall.
- Bubble and stall never modify R.

## Structure
- Shared package `y86_pkg`:
  - icode constants (IHALT..IPOPQ).
  - RNONE=4'hF, RRSP=4'h4.
  - XLEN.
  - Bubble-record constants.
- Sub-module `y86_regfile`:
  - NREG×XLEN array, two write ports (M priority), two combinational read ports with W bypass, synchronous reset.
  - The parent keeps the ID decode, valA merge and E register.

## Test plan
- Reset with stall=bubble=0: after rst, E_icode=1 and all E IDs = F. Reading any register after irmovq-free cycles returns 0.
- W_dstE=3, W_valE=0x55 while D holds OPq rA=3,rB=3 → E_valA=E_valB=0x55 at the next edge. R[3]=0x55 thereafter.
- W_dstE=4 (valE=0x100) and W_dstM=4 (valM=0x200) together → R[4]=0x200. The bypass returns 0x200 to a same-cycle pushq.
- call with D_valP=0x40 → E_valA=0x40, E_srcB=4, E_dstE=4, E_dstM=F.
- popq rA=2: E_srcA=4, E_srcB=4, E_dstE=4, E_dstM=2. Assert D_stall 2 cycles → E unchanged. Then D_bubble → E_icode=1, IDs=F.
- Assert rst mid-stream with W_dstE=5 valid → R[5] stays 0 and the E register is the bubble.
